// File: rtl/uart_frame_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : uart_frame_receiver
//  Purpose  : Assembles gated UART frames (payload + CRC-16/CCITT-FALSE),
//             latches good payloads, decodes the signed PWM setpoint and
//             counts good / rejected frames.
//  Revision : 1.0  initial release
// ============================================================================
module uart_frame_receiver #(
  parameter int PAYLOAD_BYTES  = 16,
  parameter int TIMEOUT_CYCLES = 160000
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       frame_active,
  input  logic                       rx_data_ready,
  input  logic [7:0]                 rx_data,
  output logic [PAYLOAD_BYTES*8-1:0] payload,
  output logic signed [31:0]         pwm_setpoint,
  output logic                       frame_valid,
  output logic                       frame_error,
  output logic [1:0]                 error_code,
  output logic [15:0]                good_count,
  output logic [15:0]                error_count
);

  // byte counter must hold PAYLOAD_BYTES+3 so overlength frames stay visible
  localparam int CNT_W = $clog2(PAYLOAD_BYTES + 4);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] C_FRAME_LEN = CNT_W'(PAYLOAD_BYTES + 2);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = CNT_W'(PAYLOAD_BYTES + 3);
  localparam logic [TMR_W-1:0] C_TMR_MAX   = TMR_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] C_ERR_LENGTH  = 2'd1;
  localparam logic [1:0] C_ERR_CRC     = 2'd2;
  localparam logic [1:0] C_ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECEIVE = 2'd1,
    S_CHECK   = 2'd2,
    S_ABORT   = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic                       gate_prev_q;
  logic [CNT_W-1:0]           byte_cnt_q, byte_cnt_d;
  logic [15:0]                crc_q, crc_d;
  logic [TMR_W-1:0]           idle_q, idle_d;
  logic [PAYLOAD_BYTES*8-1:0] shadow_q, shadow_d;
  logic [PAYLOAD_BYTES*8-1:0] payload_q, payload_d;
  logic [31:0]                pwm_q, pwm_d;
  logic                       frame_valid_q, frame_valid_d;
  logic                       frame_error_q, frame_error_d;
  logic [1:0]                 error_code_q, error_code_d;
  logic [15:0]                good_count_q, good_count_d;
  logic [15:0]                error_count_q, error_count_d;

  // MSB-first CRC-16 (poly 0x1021) advanced by one whole byte
  function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Next-state, datapath and result-pulse logic
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    crc_d         = crc_q;
    idle_d        = idle_q;
    shadow_d      = shadow_q;
    payload_d     = payload_q;
    pwm_d         = pwm_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    error_code_d  = error_code_q;
    good_count_d  = good_count_q;
    error_count_d = error_count_q;

    case (state_q)
      S_IDLE: begin
        if (!gate_prev_q && frame_active) begin
          byte_cnt_d = '0;
          crc_d      = 16'hFFFF;
          idle_d     = '0;
          state_d    = S_RECEIVE;
        end
      end

      S_RECEIVE: begin
        if (!frame_active) begin
          // a byte strobed together with the falling gate is dropped
          state_d = S_CHECK;
        end else if (rx_data_ready) begin
          for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            if (byte_cnt_q == CNT_W'(k)) begin
              shadow_d[8*k +: 8] = rx_data;
            end
          end
          crc_d  = crc_byte(crc_q, rx_data);
          idle_d = '0;
          if (byte_cnt_q != C_CNT_MAX) begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end else if (idle_q == C_TMR_MAX) begin
          // the error is reported on entry; ABORT only waits for the gate
          state_d       = S_ABORT;
          frame_error_d = 1'b1;
          error_code_d  = C_ERR_TIMEOUT;
          if (error_count_q != 16'hFFFF) error_count_d = error_count_q + 16'd1;
        end else begin
          idle_d = idle_q + TMR_W'(1);
        end
      end

      S_CHECK: begin
        state_d = S_IDLE;
        if (byte_cnt_q != C_FRAME_LEN) begin
          frame_error_d = 1'b1;
          error_code_d  = C_ERR_LENGTH;
          if (error_count_q != 16'hFFFF) error_count_d = error_count_q + 16'd1;
        end else if (crc_q != 16'h0000) begin
          frame_error_d = 1'b1;
          error_code_d  = C_ERR_CRC;
          if (error_count_q != 16'hFFFF) error_count_d = error_count_q + 16'd1;
        end else begin
          payload_d     = shadow_q;
          pwm_d         = shadow_q[31:0];
          frame_valid_d = 1'b1;
          if (good_count_q != 16'hFFFF) good_count_d = good_count_q + 16'd1;
        end
      end

      S_ABORT: begin
        if (!frame_active) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; gate history resets high so a gate already
  // asserted at reset release is not mistaken for a frame start
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      gate_prev_q   <= 1'b1;
      byte_cnt_q    <= '0;
      crc_q         <= 16'hFFFF;
      idle_q        <= '0;
      shadow_q      <= '0;
      payload_q     <= '0;
      pwm_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      error_code_q  <= 2'd0;
      good_count_q  <= 16'd0;
      error_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      gate_prev_q   <= frame_active;
      byte_cnt_q    <= byte_cnt_d;
      crc_q         <= crc_d;
      idle_q        <= idle_d;
      shadow_q      <= shadow_d;
      payload_q     <= payload_d;
      pwm_q         <= pwm_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      error_code_q  <= error_code_d;
      good_count_q  <= good_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign payload      = payload_q;
  assign pwm_setpoint = pwm_q;
  assign frame_valid  = frame_valid_q;
  assign frame_error  = frame_error_q;
  assign error_code   = error_code_q;
  assign good_count   = good_count_q;
  assign error_count  = error_count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_frame_receiver
//  Purpose  : Randomized and directed frames against a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_frame_receiver;
  localparam int PB = 9;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          gate;
  logic          rdy;
  logic [7:0]    dat;
  logic [PB*8-1:0] payload;
  logic [31:0]   pwm;
  logic          fv;
  logic          fe;
  logic [1:0]    ec;
  logic [15:0]   gc;
  logic [15:0]   erc;

  int checks = 0;
  int errors = 0;

  // frame-level model state
  logic [7:0] exp_pl[PB];
  int         exp_good;
  int         exp_err;
  logic [1:0] exp_code;
  logic [7:0] fr[$];

  uart_frame_receiver #(.PAYLOAD_BYTES(PB), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(clk), .RESET(rst), .frame_active(gate), .rx_data_ready(rdy), .rx_data(dat),
    .payload(payload), .pwm_setpoint(pwm), .frame_valid(fv), .frame_error(fe),
    .error_code(ec), .good_count(gc), .error_count(erc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bit-serial CRC-16/CCITT-FALSE over a byte list
  function automatic logic [15:0] crc_of(input logic [7:0] q[$]);
    logic [15:0] crc;
    logic        fb;
    crc = 16'hFFFF;
    foreach (q[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb  = crc[15] ^ q[i][b];
        crc = {crc[14:0], 1'b0};
        if (fb) crc = crc ^ 16'h1021;
      end
    end
    return crc;
  endfunction

  task automatic model_reset();
    foreach (exp_pl[k]) exp_pl[k] = 8'h00;
    exp_good = 0;
    exp_err  = 0;
    exp_code = 2'd0;
  endtask

  task automatic check_state(input string tag);
    logic [PB*8-1:0] ep;
    foreach (exp_pl[k]) ep[8*k +: 8] = exp_pl[k];
    check({tag, "_payload"}, payload, ep);
    check({tag, "_pwm"}, pwm, ep[31:0]);
    check({tag, "_code"}, ec, exp_code);
    check({tag, "_good"}, gc, exp_good);
    check({tag, "_errcnt"}, erc, exp_err);
  endtask

  // append the CRC (high byte first) to the payload bytes already in fr
  task automatic seal_frame();
    logic [15:0] c;
    c = crc_of(fr);
    fr.push_back(c[15:8]);
    fr.push_back(c[7:0]);
  endtask

  // send fr inside one gate window and check the outcome at N / N+1 / N+2
  task automatic run_frame(input string tag, input bit stray, input bit gaps);
    bit good;
    gate = 1'b1;
    tick();
    foreach (fr[i]) begin
      rdy = 1'b1;
      dat = fr[i];
      tick();
      rdy = 1'b0;
      if (gaps) repeat ($urandom_range(0, 3)) tick();
    end
    gate = 1'b0;
    if (stray) begin
      rdy = 1'b1;
      dat = 8'($urandom);
    end
    tick();
    rdy = 1'b0;
    check({tag, "_nopulse_N"}, {fv, fe}, 2'b00);
    good = 1'b0;
    if (fr.size() != PB + 2) begin
      exp_code = 2'd1;
      exp_err++;
    end else if (crc_of(fr) != 16'h0000) begin
      exp_code = 2'd2;
      exp_err++;
    end else begin
      good = 1'b1;
      for (int k = 0; k < PB; k++) exp_pl[k] = fr[k];
      exp_good++;
    end
    tick();
    check({tag, "_valid"}, fv, good);
    check({tag, "_error"}, fe, !good);
    check_state(tag);
    tick();
    check({tag, "_pulse_end"}, {fv, fe}, 2'b00);
  endtask

  task automatic random_payload();
    fr.delete();
    for (int k = 0; k < PB; k++) fr.push_back(8'($urandom));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int kind;
    int idx;
    string s;
    rst  = 1'b1;
    gate = 1'b0;
    rdy  = 1'b0;
    dat  = 8'h00;
    model_reset();
    tick();
    tick();
    check("reset_pulses", {fv, fe}, 2'b00);
    check_state("reset");
    rst = 1'b0;
    tick();

    // known CRC-16/CCITT-FALSE check value of "123456789" is 0x29B1
    s = "123456789";
    fr.delete();
    for (int k = 0; k < 9; k++) fr.push_back(s[k]);
    fr.push_back(8'h29);
    fr.push_back(8'hB1);
    run_frame("good_123", 1'b0, 1'b0);
    check("good_123_byte0", payload[7:0], 8'h31);

    // same frame with the last byte corrupted
    fr[10] = 8'hB0;
    run_frame("bad_crc", 1'b0, 1'b1);

    // signed setpoint decode
    random_payload();
    fr[0] = 8'h18; fr[1] = 8'hFC; fr[2] = 8'hFF; fr[3] = 8'hFF;
    seal_frame();
    run_frame("setpoint", 1'b0, 1'b1);
    check("setpoint_m1000", pwm, 32'hFFFF_FC18);

    // one short, with a byte on the falling gate that must not be counted
    random_payload();
    seal_frame();
    void'(fr.pop_back());
    run_frame("short_stray", 1'b1, 1'b1);
    // one long
    random_payload();
    seal_frame();
    fr.push_back(8'h55);
    run_frame("long1", 1'b0, 1'b1);
    // correct length with a stray byte on the falling gate is still good
    random_payload();
    seal_frame();
    run_frame("good_stray", 1'b1, 1'b1);

    // timeout: 3 bytes then silence
    gate = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      rdy = 1'b1;
      dat = 8'($urandom);
      tick();
      rdy = 1'b0;
    end
    cnt = 0;
    while (fe !== 1'b1 && cnt < 3 * TO) begin
      tick();
      cnt++;
    end
    exp_code = 2'd3;
    exp_err++;
    check("timeout_latency", cnt, TO + 1);
    check("timeout_valid", fv, 1'b0);
    check_state("timeout");
    tick();
    check("timeout_pulse_end", fe, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rdy = 1'b1;
      dat = 8'($urandom);
      tick();
      rdy = 1'b0;
      check("abort_ignore", {fv, fe}, 2'b00);
    end
    gate = 1'b0;
    tick();
    tick();
    check("abort_exit", {fv, fe}, 2'b00);
    check_state("abort_exit");
    random_payload();
    seal_frame();
    run_frame("after_timeout", 1'b0, 1'b1);

    // reset during byte 5, gate held high through reset release
    gate = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      rdy = 1'b1;
      dat = 8'($urandom);
      tick();
      rdy = 1'b0;
    end
    rdy = 1'b1;
    dat = 8'hA5;
    rst = 1'b1;
    tick();
    rdy = 1'b0;
    tick();
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rst_mid_nopulse", {fv, fe}, 2'b00);
    end
    check_state("rst_mid");
    gate = 1'b0;
    tick();
    tick();
    check("rst_gate_fall", {fv, fe}, 2'b00);
    check_state("rst_gate_fall");
    random_payload();
    seal_frame();
    run_frame("after_reset", 1'b0, 1'b1);

    // randomized mix of good, corrupted, short and long frames
    for (int n = 0; n < 40; n++) begin
      random_payload();
      seal_frame();
      kind = $urandom_range(0, 3);
      if (kind == 1) begin
        idx = $urandom_range(0, PB + 1);
        fr[idx] = fr[idx] ^ (8'h01 << $urandom_range(0, 7));
      end else if (kind == 2) begin
        idx = $urandom_range(0, PB + 1);
        while (fr.size() > idx) void'(fr.pop_back());
      end else if (kind == 3) begin
        idx = $urandom_range(1, 12);
        for (int k = 0; k < idx; k++) fr.push_back(8'($urandom));
      end
      run_frame("rand", 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_frame_receiver.md
# uart_frame_receiver

Frame assembler between the byte-level `uart_rx` and the motor-control registers. It collects one gated frame of PAYLOAD_BYTES payload bytes plus a 2-byte CRC and checks CRC-16/CCITT-FALSE over the whole frame. On a good frame it latches the payload and decodes the signed PWM setpoint for `BLDC_COMMUTATION`. Bad frames are discarded and counted; the payload registers keep their last good value.

## Interface
- PAYLOAD_BYTES, 16, payload bytes per frame; legal range 4..64.
- TIMEOUT_CYCLES, 160000, maximum idle cycles between bytes inside a frame (10 ms at 16 MHz).
- CLK  input  1  system clock, 16 MHz.
- RESET  input  1  asynchronous, active-high reset.
- frame_active  input  1  frame gate, active-high. The top level drives it as the inverted transmission pin.
- rx_data_ready  input  1  single-cycle strobe from `uart_rx`; marks rx_data as valid.
- rx_data  input  8  received byte.
- payload  output  PAYLOAD_BYTES*8  last good payload; byte k occupies bits [8k+7:8k].
- pwm_setpoint  output  32  signed; payload bytes 0..3, little-endian.
- frame_valid  output  1  one-cycle pulse for a good frame.
- frame_error  output  1  one-cycle pulse for a rejected frame.
- error_code  output  2  code for the most recent rejection: 1 = length, 2 = CRC, 3 = timeout.
- good_count  output  16  good frames; saturates at 0xFFFF.
- error_count  output  16  rejected frames; saturates at 0xFFFF.

## Operation
- Frame length is PAYLOAD_BYTES+2. The CRC is sent high byte first.
- CRC parameters: poly 0x1021, init 0xFFFF, no bit reflection, no output XOR. The CRC is updated one byte per cycle, combinationally, in the cycle rx_data_ready is high.
- Acceptance test: the running CRC over all received bytes, including the two CRC bytes, must equal 0x0000.
- States:
  - IDLE: on a rising edge of frame_active (previous sample 0, current sample 1), clear byte_cnt, load CRC with 0xFFFF, clear the idle timer, and go to RECEIVE.
  - RECEIVE, frame_active=1 and rx_data_ready=1:
    - Bytes with index below PAYLOAD_BYTES go to a shadow buffer (never directly to payload).
    - Update the CRC and increment byte_cnt.
    - byte_cnt saturates at PAYLOAD_BYTES+3, so any overlength frame is detected.
    - Clear the idle timer.
  - RECEIVE, frame_active=1 and no byte this cycle: increment the idle timer. When it reaches TIMEOUT_CYCLES, go to ABORT with code 3.
  - RECEIVE, frame_active=0: go to CHECK. A byte strobed in this same cycle is ignored.
  - CHECK, one cycle:
    - byte_cnt ≠ PAYLOAD_BYTES+2: reject with code 1.
    - Else CRC ≠ 0: reject with code 2.
    - Else accept: copy the shadow buffer to payload and pwm_setpoint, pulse frame_valid, increment good_count.
    - Next state is IDLE.
  - ABORT: pulse frame_error, record error_code, increment error_count, then wait in ABORT until frame_active=0 before returning to IDLE.
- A rejection from CHECK also pulses frame_error, records error_code and increments error_count.
- The frame_active previous-sample register resets to 1. A gate already high when reset releases therefore does not start a frame.

## Timing
- Reset values:
  - payload = 0, pwm_setpoint = 0;
  - frame_valid = 0, frame_error = 0, error_code = 0;
  - good_count = 0, error_count = 0;
  - state IDLE.
- Reset mid-frame: the partial frame is discarded and no pulse is produced.
- Result latency: frame_active is first sampled low at clock edge N.
  - State is CHECK after edge N.
  - frame_valid or frame_error is high for exactly the cycle following edge N+1.
  - payload and pwm_setpoint update at edge N+1.
- Timeout abort: frame_error goes high for one cycle, one cycle after the timer reaches TIMEOUT_CYCLES.
- Back-to-back frames: a new rising edge of frame_active is accepted in the first IDLE cycle after CHECK. A frame_active that goes high again while in CHECK is missed.
- Counters hold at 0xFFFF. frame_valid and frame_error are never high in the same cycle.

## Test plan
- Good frame: PAYLOAD_BYTES=9, bytes "123456789" followed by 0x29, 0xB1, gate then dropped → frame_valid for 1 cycle at N+1, payload byte 0 = 0x31, good_count = 1.
- Setpoint decode: PAYLOAD_BYTES=16, payload bytes 0..3 = 0x18 0xFC 0xFF 0xFF, correct CRC → pwm_setpoint = -1000; all other outputs unchanged except good_count.
- Corrupt CRC: same frame as the good-frame case with last byte 0xB0 → frame_error, error_code = 2, payload keeps its previous value, error_count increments.
- Length errors: 17 bytes, then 19 bytes → error_code = 1 each time. A byte strobed in the same cycle the gate falls is not counted.
- Timeout: gate held high, 3 bytes, then silence for TIMEOUT_CYCLES → frame_error, error_code = 3. Bytes arriving afterwards are ignored until the gate drops and rises again.
- Reset during byte 5: no pulse. A gate held high through reset release is ignored; the next full frame is accepted.
